// File: rtl/retire_map_pkg.sv
// Shared types and sizing for the commit-side retirement map and its free list.
package retire_map_pkg;

    localparam int NUM_ARCH_REGS = 32;
    localparam int NUM_REGS      = 64;
    localparam int PS_WIDTH      = $clog2(NUM_REGS);
    localparam int FL_DEPTH      = NUM_REGS - NUM_ARCH_REGS;
    localparam int FL_PTR_W      = $clog2(FL_DEPTH);
    localparam int FL_CNT_W      = $clog2(FL_DEPTH + 1);

    typedef logic [PS_WIDTH-1:0] phys_reg_t;
    typedef logic [4:0]          arch_reg_t;
    typedef logic [FL_PTR_W-1:0] fl_ptr_t;
    typedef logic [FL_CNT_W-1:0] fl_cnt_t;

    typedef struct packed {
        logic      valid;
        arch_reg_t rd;
        phys_reg_t pd;
        logic      jump;
    } commit_pkt_t;

    // Free-list pointers wrap at FL_DEPTH, which need not be a power of two.
    function automatic fl_ptr_t fl_ptr_inc(input fl_ptr_t p);
        if (p == fl_ptr_t'(FL_DEPTH - 1)) begin
            return fl_ptr_t'(0);
        end else begin
            return p + fl_ptr_t'(1);
        end
    endfunction

endpackage

// File: rtl/retire_map_chk.sv
// Simulation-only protocol checks for the physical-register free list.
module retire_map_chk
    import retire_map_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    i_push,
    input  fl_cnt_t i_count
);

    // A reclaimed register must correspond to an allocation still in flight.
    a_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(i_push && (i_count == fl_cnt_t'(FL_DEPTH))));

endmodule

// File: rtl/retire_map_free_list.sv
// Circular physical-register free list; head pops to rename, tail reclaims on
// commit, rhead tracks the oldest uncommitted allocation for flush rewind.
module free_list_fifo
    import retire_map_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      i_pop,
    input  logic      i_push,
    input  phys_reg_t i_push_pd,
    input  logic      i_retire,
    input  logic      i_rewind,
    output logic      o_valid,
    output phys_reg_t o_head_pd,
    output fl_cnt_t   o_count
);

    phys_reg_t r_fl [FL_DEPTH];
    fl_ptr_t   r_head;
    fl_ptr_t   r_tail;
    fl_ptr_t   r_rhead;
    fl_cnt_t   r_count;

    logic      w_pop_fire;
    fl_ptr_t   w_rhead_nxt;
    fl_ptr_t   w_head_nxt;
    fl_cnt_t   w_count_nxt;

    // Next-state for pointers and occupancy; rewind sees the post-retire rhead.
    always_comb begin
        w_pop_fire  = i_pop && (r_count != fl_cnt_t'(0)) && !i_rewind;
        w_rhead_nxt = r_rhead;
        w_head_nxt  = r_head;
        w_count_nxt = r_count;
        if (i_retire) begin
            w_rhead_nxt = fl_ptr_inc(r_rhead);
        end else begin
            w_rhead_nxt = r_rhead;
        end
        if (i_rewind) begin
            w_head_nxt  = w_rhead_nxt;
            w_count_nxt = fl_cnt_t'(FL_DEPTH);
        end else begin
            if (w_pop_fire) begin
                w_head_nxt = fl_ptr_inc(r_head);
            end else begin
                w_head_nxt = r_head;
            end
            case ({i_push, w_pop_fire})
                2'b10:   w_count_nxt = r_count + fl_cnt_t'(1);
                2'b01:   w_count_nxt = r_count - fl_cnt_t'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < FL_DEPTH; k++) begin
                r_fl[k] <= phys_reg_t'(NUM_ARCH_REGS + k);
            end
            r_head  <= fl_ptr_t'(0);
            r_tail  <= fl_ptr_t'(0);
            r_rhead <= fl_ptr_t'(0);
            r_count <= fl_cnt_t'(FL_DEPTH);
        end else begin
            if (i_push) begin
                r_fl[r_tail] <= i_push_pd;
                r_tail       <= fl_ptr_inc(r_tail);
            end
            r_head  <= w_head_nxt;
            r_rhead <= w_rhead_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign o_valid   = (r_count != fl_cnt_t'(0));
    assign o_head_pd = r_fl[r_head];
    assign o_count   = r_count;

    retire_map_chk u_chk (
        .clk     (clk),
        .rst     (rst),
        .i_push  (i_push),
        .i_count (r_count)
    );

endmodule

// File: rtl/retire_map.sv
// Retirement register file plus physical free list; the RRF image is bypassed
// with the same-cycle commit so a redirecting JAL reloads its own mapping.
module retire_map
    import retire_map_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_alloc_req,
    output logic                           o_alloc_valid,
    output phys_reg_t                      o_alloc_pd,
    input  logic                           i_commit_valid,
    input  arch_reg_t                      i_commit_rd,
    input  phys_reg_t                      i_commit_pd,
    input  logic                           i_jump_commit,
    output phys_reg_t [NUM_ARCH_REGS-1:0]  o_rrf,
    output fl_cnt_t                        o_free_count
);

    commit_pkt_t                    w_commit;
    logic                           w_commit_fire;
    phys_reg_t                      w_old_pd;
    phys_reg_t [NUM_ARCH_REGS-1:0]  r_rrf;

    assign w_commit      = '{valid: i_commit_valid, rd: i_commit_rd,
                             pd: i_commit_pd, jump: i_jump_commit};
    assign w_commit_fire = w_commit.valid && (w_commit.rd != arch_reg_t'(0));
    assign w_old_pd      = r_rrf[w_commit.rd];

    // Committed architectural mapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                r_rrf[i] <= phys_reg_t'(i);
            end
        end else if (w_commit_fire) begin
            r_rrf[w_commit.rd] <= w_commit.pd;
        end
    end

    // Bypass the in-flight commit onto the exported image.
    always_comb begin
        o_rrf = r_rrf;
        if (w_commit_fire) begin
            o_rrf[w_commit.rd] = w_commit.pd;
        end else begin
            o_rrf = r_rrf;
        end
    end

    free_list_fifo u_free_list (
        .clk       (clk),
        .rst       (rst),
        .i_pop     (i_alloc_req),
        .i_push    (w_commit_fire),
        .i_push_pd (w_old_pd),
        .i_retire  (w_commit_fire),
        .i_rewind  (w_commit.jump),
        .o_valid   (o_alloc_valid),
        .o_head_pd (o_alloc_pd),
        .o_count   (o_free_count)
    );

endmodule

// File: tb/tb_retire_map.sv
// Self-checking bench for retire_map: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_retire_map;
    import retire_map_pkg::*;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          i_alloc_req;
    logic                          o_alloc_valid;
    phys_reg_t                     o_alloc_pd;
    logic                          i_commit_valid;
    arch_reg_t                     i_commit_rd;
    phys_reg_t                     i_commit_pd;
    logic                          i_jump_commit;
    phys_reg_t [NUM_ARCH_REGS-1:0] o_rrf;
    fl_cnt_t                       o_free_count;

    always #5 clk = ~clk;

    retire_map dut (
        .clk            (clk),
        .rst            (rst),
        .i_alloc_req    (i_alloc_req),
        .o_alloc_valid  (o_alloc_valid),
        .o_alloc_pd     (o_alloc_pd),
        .i_commit_valid (i_commit_valid),
        .i_commit_rd    (i_commit_rd),
        .i_commit_pd    (i_commit_pd),
        .i_jump_commit  (i_jump_commit),
        .o_rrf          (o_rrf),
        .o_free_count   (o_free_count)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model: free registers in hand-out order, and uncommitted allocations oldest first.
    int m_rrf [NUM_ARCH_REGS];
    int m_free [$];
    int m_infl [$];

    typedef struct {
        int req; int cv; int rd; int pd; int jmp;
        int e_valid; int e_pd; int e_cnt; int r_idx; int e_rrf;
    } vec_t;

    vec_t tbl [12];

    function automatic vec_t mk(int req, int cv, int rd, int pd, int jmp,
                                int ev, int epd, int ecnt, int ridx, int erv);
        vec_t v;
        v.req = req; v.cv = cv; v.rd = rd; v.pd = pd; v.jmp = jmp;
        v.e_valid = ev; v.e_pd = epd; v.e_cnt = ecnt; v.r_idx = ridx; v.e_rrf = erv;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_ARCH_REGS; i++) m_rrf[i] = i;
        m_free.delete();
        m_infl.delete();
        for (int k = 0; k < FL_DEPTH; k++) m_free.push_back(NUM_ARCH_REGS + k);
    endtask

    task automatic model_step(input int req, input int cv, input int rd, input int pd, input int jmp);
        bit hon;
        hon = (req != 0) && (m_free.size() != 0) && (jmp == 0);
        if (cv != 0 && rd != 0) begin
            m_free.push_back(m_rrf[rd]);
            m_rrf[rd] = pd;
            if (m_infl.size() != 0) void'(m_infl.pop_front());
        end
        if (hon) m_infl.push_back(m_free.pop_front());
        if (jmp != 0) begin
            m_free = {m_infl, m_free};
            m_infl.delete();
        end
    endtask

    task automatic set_inputs(input int req, input int cv, input int rd, input int pd, input int jmp);
        i_alloc_req    = (req != 0);
        i_commit_valid = (cv != 0);
        i_commit_rd    = arch_reg_t'(rd);
        i_commit_pd    = phys_reg_t'(pd);
        i_jump_commit  = (jmp != 0);
    endtask

    task automatic check_model(input string tag, input int cv, input int rd, input int pd);
        phys_reg_t [NUM_ARCH_REGS-1:0] exp_v;
        bit ev;
        ev = (m_free.size() != 0);
        check({tag, "_valid"}, int'(o_alloc_valid), int'(ev));
        if (ev) check({tag, "_pd"}, int'(o_alloc_pd), m_free[0]);
        check({tag, "_count"}, int'(o_free_count), m_free.size());
        for (int i = 0; i < NUM_ARCH_REGS; i++) exp_v[i] = phys_reg_t'(m_rrf[i]);
        if (cv != 0 && rd != 0) exp_v[rd] = phys_reg_t'(pd);
        n_chk++;
        if (o_rrf !== exp_v) begin
            n_fail++;
            $display("FAIL %s_rrf: got %h expected %h at %0t", tag, o_rrf, exp_v, $time);
        end
    endtask

    task automatic drive(input string tag, input int req, input int cv, input int rd,
                         input int pd, input int jmp);
        @(negedge clk);
        set_inputs(req, cv, rd, pd, jmp);
        #1;
        check_model(tag, cv, rd, pd);
        @(posedge clk);
        model_step(req, cv, rd, pd, jmp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_inputs(0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int rd, pd, cv;
        rst = 1'b1;
        set_inputs(0, 0, 0, 0, 0);
        // Directed walk from reset: pops, bypassed commit, flush rewind, commit+flush+pop.
        tbl[0]  = mk(1, 0,  0,  0, 0, 1, 32, 32,  0,  0);
        tbl[1]  = mk(1, 0,  0,  0, 0, 1, 33, 31,  0,  0);
        tbl[2]  = mk(1, 0,  0,  0, 0, 1, 34, 30,  0,  0);
        tbl[3]  = mk(0, 1,  5, 32, 0, 1, 35, 29,  5, 32);
        tbl[4]  = mk(0, 0,  0,  0, 0, 1, 35, 30,  5, 32);
        tbl[5]  = mk(0, 1,  1, 33, 0, 1, 35, 30,  1, 33);
        tbl[6]  = mk(0, 0,  0,  0, 1, 1, 35, 31,  1, 33);
        tbl[7]  = mk(1, 0,  0,  0, 0, 1, 34, 32,  1, 33);
        tbl[8]  = mk(1, 1, 31, 34, 1, 1, 35, 31, 31, 34);
        tbl[9]  = mk(0, 0,  0,  0, 0, 1, 35, 32, 31, 34);
        tbl[10] = mk(0, 1,  0, 50, 0, 1, 35, 32,  0,  0);
        tbl[11] = mk(0, 0,  0,  0, 0, 1, 35, 32,  5, 32);

        do_reset();
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            set_inputs(tbl[t].req, tbl[t].cv, tbl[t].rd, tbl[t].pd, tbl[t].jmp);
            #1;
            check($sformatf("tbl%0d_valid", t), int'(o_alloc_valid), tbl[t].e_valid);
            check($sformatf("tbl%0d_pd", t), int'(o_alloc_pd), tbl[t].e_pd);
            check($sformatf("tbl%0d_count", t), int'(o_free_count), tbl[t].e_cnt);
            check($sformatf("tbl%0d_rrf", t), int'(o_rrf[tbl[t].r_idx]), tbl[t].e_rrf);
            @(posedge clk);
            model_step(tbl[t].req, tbl[t].cv, tbl[t].rd, tbl[t].pd, tbl[t].jmp);
        end

        // Drain the list, pop while empty, then refill from a commit.
        do_reset();
        for (int k = 0; k < FL_DEPTH; k++) drive("drain", 1, 0, 0, 0, 0);
        drive("empty_pop", 1, 0, 0, 0, 0);
        drive("empty_commit", 1, 1, 7, 32, 0);
        @(negedge clk);
        set_inputs(0, 0, 0, 0, 0);
        #1;
        check("refill_valid", int'(o_alloc_valid), 1);
        check("refill_pd", int'(o_alloc_pd), 7);
        check("refill_count", int'(o_free_count), 1);
        @(posedge clk);
        model_step(0, 0, 0, 0, 0);

        // Steady pop/commit pairs wrap every pointer past FL_DEPTH.
        do_reset();
        drive("wrap_first", 1, 0, 0, 0, 0);
        for (int k = 0; k < 40; k++) begin
            rd = $urandom_range(31, 1);
            drive("wrap", 1, 1, rd, m_infl[0], 0);
        end
        drive("wrap_end", 0, 0, 0, 0, 0);

        // Random traffic, including flushes and mid-operation reset.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(99, 0) == 0) begin
                do_reset();
            end else begin
                cv = (m_infl.size() != 0) && ($urandom_range(1, 0) == 1);
                rd = $urandom_range(31, 0);
                pd = cv ? m_infl[0] : $urandom_range(NUM_REGS - 1, 0);
                drive("rand", $urandom_range(2, 0) != 0, cv, rd, pd,
                      $urandom_range(15, 0) == 0);
            end
        end
        drive("rand_end", 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
